// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and state encoding for the seven-segment scan reader
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  // Active-high g..a pattern that means "digit switched off"
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Hex digit -> active-high g..a pattern; entry i is the glyph for nibble i
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef logic [1:0] state_t;

  localparam state_t ST_WAIT   = 2'd0;
  localparam state_t ST_SETTLE = 2'd1;
  localparam state_t ST_HELD   = 2'd2;

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - reverse lookup of a seven-segment glyph into a hex nibble
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       bad
);

  // Search the glyph table; anything that is neither a glyph nor blank is flagged bad
  always_comb begin
    nibble = 4'd0;
    blank  = (pat == SEG_BLANK);
    bad    = (pat != SEG_BLANK);
    for (int i = 0; i < 16; i++) begin
      if (pat == HEX_SEG_TABLE[i]) begin
        nibble = 4'(i);
        bad    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// rtl/seg7_scan_reader.sv - decodes a scanned 4-digit seven-segment bus back into a 16-bit word
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [7:0]  seg,
  output logic [15:0] value,
  output logic [3:0]  dp,
  output logic [3:0]  blank,
  output logic [3:0]  bad,
  output logic        frame_valid,
  output logic        scan_err
);

  localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_CYCLES);

  logic [3:0]       an_q, an_p;
  logic [7:0]       seg_q, seg_p;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       seen;

  logic [15:0] sh_value;
  logic [3:0]  sh_dp, sh_blank, sh_bad;

  logic [3:0]  an_low;
  logic        any_low, one_low, changed, at_limit, cap_en, err_en;
  logic [1:0]  dig_idx;
  logic [6:0]  pat;
  logic [3:0]  dec_nib;
  logic        dec_blank, dec_bad;

  logic [3:0]  seen_nxt;
  logic [15:0] nxt_value;
  logic [3:0]  nxt_dp, nxt_blank, nxt_bad;

  assign pat = ~seg_q[6:0];

  seg7_pattern_decode u_decode (
    .pat    (pat),
    .nibble (dec_nib),
    .blank  (dec_blank),
    .bad    (dec_bad)
  );

  // Bus classification: which digit is lit, and did the bus move since last cycle
  always_comb begin
    an_low   = ~an_q;
    any_low  = |an_low;
    one_low  = any_low && ((an_low & (an_low - 4'd1)) == 4'd0);
    changed  = (an_q != an_p) || (seg_q != seg_p);
    at_limit = (state == ST_SETTLE) && !changed && (cnt == SETTLE_MAX);
    cap_en   = at_limit && one_low;
    err_en   = at_limit && !one_low;
    dig_idx  = 2'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_low[i]) dig_idx = 2'(i);
    end
  end

  // Shadow slots as they will look after this cycle's capture, so a completing
  // frame already contains the digit captured on the same cycle
  always_comb begin
    seen_nxt  = seen;
    nxt_value = sh_value;
    nxt_dp    = sh_dp;
    nxt_blank = sh_blank;
    nxt_bad   = sh_bad;
    if (cap_en) begin
      seen_nxt[dig_idx]                 = 1'b1;
      nxt_value[{dig_idx, 2'b00} +: 4]  = dec_nib;
      nxt_dp[dig_idx]                   = ~seg_q[7];
      nxt_blank[dig_idx]                = dec_blank;
      nxt_bad[dig_idx]                  = dec_bad;
    end
  end

  // Input registers and the settle/hold state machine
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q     <= 4'hF;
      an_p     <= 4'hF;
      seg_q    <= 8'hFF;
      seg_p    <= 8'hFF;
      state    <= ST_WAIT;
      cnt      <= '0;
      scan_err <= 1'b0;
    end else begin
      an_q  <= an;
      seg_q <= seg;
      an_p  <= an_q;
      seg_p <= seg_q;
      if (err_en) scan_err <= 1'b1;
      case (state)
        ST_WAIT: begin
          if (any_low) begin
            cnt   <= CNT_W'(1);
            state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (changed) begin
            cnt <= CNT_W'(1);
            if (!any_low) state <= ST_WAIT;
          end else if (cnt == SETTLE_MAX) begin
            state <= ST_HELD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (changed) state <= ST_WAIT;
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

  // Shadow capture and frame publication
  always_ff @(posedge clk) begin
    if (rst) begin
      seen        <= 4'd0;
      sh_value    <= 16'd0;
      sh_dp       <= 4'd0;
      sh_blank    <= 4'd0;
      sh_bad      <= 4'd0;
      value       <= 16'd0;
      dp          <= 4'd0;
      blank       <= 4'd0;
      bad         <= 4'd0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (cap_en) begin
        sh_value <= nxt_value;
        sh_dp    <= nxt_dp;
        sh_blank <= nxt_blank;
        sh_bad   <= nxt_bad;
        if (seen_nxt == 4'hF) begin
          value       <= nxt_value;
          dp          <= nxt_dp;
          blank       <= nxt_blank;
          bad         <= nxt_bad;
          frame_valid <= 1'b1;
          seen        <= 4'd0;
        end else begin
          seen <= seen_nxt;
        end
      end
    end
  end

endmodule
